tri_fetch_sched: RTL and testbench
==================================

# tri_fetch_sched

Credit-based fetch scheduler for the mesh triangle BROM. On a frame start it issues triangle IDs `0..count-1` as BROM read addresses and tracks the reads in flight across the fixed BROM read latency. Returned triangles land in a small FIFO, and the FIFO drains to the rasterizer through a valid/ready handshake. The BROM is never frozen; backpressure is absorbed by credits, and the block replaces the free-running counter-and-pause scheme ahead of the rasterizer.

## Interface
- `MAX_TRIS`, 1024: BROM depth; ID width `ID_W = $clog2(MAX_TRIS)`.
- `READ_LATENCY`, 2: BROM address-to-data cycles (HIGH_PERFORMANCE mode).
- `FIFO_DEPTH`, 4: return buffer entries; must be ≥ `READ_LATENCY+2` for full rate.
- `clk_in`  in  1  system clock; the only clock.
- `rst_n_in`  in  1  reset; asynchronous, active-low.
- `frame_start_in`  in  1  one-cycle pulse that starts a frame; honoured only in IDLE.
- `tri_count_in`  in  ID_W+1  number of triangles in the frame; sampled on an accepted `frame_start_in`.
- `rom_en_out`  out  1  read strobe to the BROM `ena`/`regcea` path.
- `rom_addr_out`  out  ID_W  BROM address.
- `rom_data_in`  in  144  BROM data, valid `READ_LATENCY` cycles after its strobe.
- `valid_out`  out  1  FIFO head valid.
- `ready_in`  in  1  downstream ready.
- `tri_vertices_out`  out  [2:0][2:0][15:0]  head triangle; `[v][c] = data[48v+16c +: 16]`.
- `tri_id_out`  out  ID_W  head triangle ID.
- `last_tri_out`  out  1  head is the final triangle of the frame.
- `busy_out`  out  1  high whenever the state is not IDLE.
- `frame_done_out`  out  1  one-cycle pulse after the last triangle handshake.

## Operation
- **States**: IDLE, ISSUE, DRAIN.
- **IDLE → ISSUE**: on `frame_start_in`.
  - The count latches as `min(tri_count_in, MAX_TRIS)`.
  - The issue counter clears to 0.
- **Zero count**: `frame_start_in` with count 0 goes IDLE → IDLE. `frame_done_out` pulses on the next cycle and no `valid_out` occurs.
- **Issue rule**: in ISSUE, a read issues (`rom_en_out=1`, `rom_addr_out`=issue counter) when `inflight + occupancy - pop < FIFO_DEPTH`.
  - `pop = valid_out & ready_in`.
  - The issue counter then increments.
- **Tag pipeline**: `READ_LATENCY` stages of {valid, id, last}, shifted every cycle and never frozen.
  - The tag exiting the pipeline writes `{rom_data_in, id, last}` into the FIFO.
  - The credit rule guarantees the FIFO is never full on a write. A write into a full FIFO is an assertion failure.
- **ISSUE → DRAIN**: when the read for ID `count-1` issues. That tag carries `last=1`.
- **DRAIN → IDLE**: on handshake of the head with `last_tri_out=1`. `frame_done_out` pulses in the following cycle.
- **Ignored start**: `frame_start_in` in ISSUE or DRAIN is ignored and does not queue.
- **Pop order**: FIFO pops strictly in ID order.
- **Holding**: `valid_out` and head data hold stable while `ready_in` is low.
- **Simultaneous events**: push and pop in the same cycle leave occupancy unchanged.
- **Asynchronous reset**, including mid-frame:
  - all outputs → 0, state → IDLE;
  - tag pipeline, FIFO and counters clear;
  - in-flight reads are discarded.

## Timing
- Frame start accepted in cycle 0 → first `rom_en_out` in cycle 1 with addr 0.
- The first triangle is written in cycle `1+READ_LATENCY` and `valid_out` rises in cycle `2+READ_LATENCY`, which is cycle 4 by default.
- With `ready_in` held high and `FIFO_DEPTH ≥ READ_LATENCY+2`, the block sustains 1 triangle per cycle. An N-triangle frame finishes its last handshake in cycle `N+1+READ_LATENCY`.
- No combinational path from `ready_in` to `valid_out`. `ready_in` reaches only `rom_en_out` through the credit rule.

## Structure
- `graphics_pkg`:
  - `TRI_WIDTH=144`;
  - `tri_t` typedef for `[2:0][2:0][15:0]`;
  - the state enum `tri_sched_state_t`.
- One sub-module, `tri_sync_fifo`: a parameterized synchronous first-word-fallthrough FIFO with width, depth, occupancy output, and the same async active-low reset.
- Top level: FSM, credit counter, tag pipeline and field unpacking.

## Test plan
- **Full-rate frame**: count=12, `ready_in`=1, BROM model holds `data=id` → `valid_out` in cycles 4..15 with IDs 0..11 in order. `last_tri_out` only on ID 11, `frame_done_out` in cycle 16, `busy_out` low from cycle 16.
- **Backpressure**: count=12, `ready_in` low in cycles 5..20 → no more than `FIFO_DEPTH` reads outstanding, no FIFO overflow, all 12 IDs delivered once each in order, head stable while stalled.
- **Random ready**: 50% random `ready_in`, count=1024 → every ID 0..1023 delivered once, and `frame_done_out` pulses once.
- **Edge counts**: count=0 → `frame_done_out` next cycle and no `valid_out`. count=2000 → clamps to 1024 triangles.
- **Ignored start**: `frame_start_in` pulsed during ISSUE and during DRAIN → ignored, and the frame completes normally with its original count.
- **Reset mid-frame**: `rst_n_in` asserted at triangle 5 of 12 → all outputs 0 immediately. After release, a new frame with count=3 returns IDs 0,1,2 and no stale data.

Source files
------------

// File: rtl/graphics_pkg.sv
// Shared types for the mesh triangle fetch path: triangle payload layout and scheduler states.
package graphics_pkg;

    localparam int unsigned TRI_WIDTH = 144;
    localparam int unsigned COORD_W   = 16;

    // [vertex][component] coordinate words, vertex-major
    typedef logic [2:0][2:0][COORD_W-1:0] tri_t;

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_ISSUE = 2'd1,
        SCHED_DRAIN = 2'd2
    } tri_sched_state_t;

endpackage

// File: rtl/tri_fetch_sched_if.sv
// BROM read port plus rasterizer valid/ready stream of the triangle fetch scheduler.
interface tri_fetch_sched_if #(
    parameter int unsigned ID_W = 10
);
    import graphics_pkg::*;

    logic                 rom_en_out;
    logic [ID_W-1:0]      rom_addr_out;
    logic [TRI_WIDTH-1:0] rom_data_in;
    logic                 valid_out;
    logic                 ready_in;
    tri_t                 tri_vertices_out;
    logic [ID_W-1:0]      tri_id_out;
    logic                 last_tri_out;

    modport master (
        output rom_en_out, rom_addr_out, valid_out, tri_vertices_out, tri_id_out, last_tri_out,
        input  rom_data_in, ready_in
    );

    modport slave (
        input  rom_en_out, rom_addr_out, valid_out, tri_vertices_out, tri_id_out, last_tri_out,
        output rom_data_in, ready_in
    );

endinterface

// File: rtl/tri_sync_fifo.sv
// Synchronous first-word-fallthrough FIFO with occupancy output; head is readable while valid.
module tri_sync_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic [OCC_W-1:0] occupancy
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             do_wr, do_rd;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_wr    = wr_en && (occ_q != OCC_W'(DEPTH));
        do_rd    = rd_en && (occ_q != '0);
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_rd) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        occ_d = occ_q + OCC_W'(do_wr) - OCC_W'(do_rd);
    end

    // Storage is reset too so a cleared FIFO presents an all-zero head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign rd_data   = mem_q[rd_ptr_q];
    assign valid     = (occ_q != '0);
    assign occupancy = occ_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        wr_en |-> (occ_q != OCC_W'(DEPTH)));

endmodule

// File: rtl/tri_fetch_sched.sv
// Credit-based triangle fetch scheduler: issues BROM reads 0..count-1, tracks them across the
// fixed read latency with a tag pipeline and buffers returns in a FIFO toward the rasterizer.
module tri_fetch_sched
    import graphics_pkg::*;
#(
    parameter  int unsigned MAX_TRIS     = 1024,
    parameter  int unsigned READ_LATENCY = 2,
    parameter  int unsigned FIFO_DEPTH   = 4,
    localparam int unsigned ID_W         = $clog2(MAX_TRIS)
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            frame_start_in,
    input  logic [ID_W:0]   tri_count_in,
    tri_fetch_sched_if.master bus,
    output logic            busy_out,
    output logic            frame_done_out
);

    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CR_W  = $clog2(FIFO_DEPTH + READ_LATENCY + 1) + 1;
    localparam int unsigned ENT_W = TRI_WIDTH + ID_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'(SCHED_IDLE);
    localparam logic [1:0] ST_ISSUE = 2'(SCHED_ISSUE);
    localparam logic [1:0] ST_DRAIN = 2'(SCHED_DRAIN);

    logic [1:0]                         state_q, state_d;
    logic [ID_W-1:0]                    issue_cnt_q, issue_cnt_d;
    logic [ID_W-1:0]                    last_id_q, last_id_d;
    logic [CR_W-1:0]                    inflight_q, inflight_d;
    logic [READ_LATENCY-1:0]            tag_vld_q, tag_vld_d;
    logic [READ_LATENCY-1:0]            tag_last_q, tag_last_d;
    logic [READ_LATENCY-1:0][ID_W-1:0]  tag_id_q, tag_id_d;
    logic                               frame_done_q, frame_done_d;

    logic                 issue_c, pop_c, is_last_c;
    logic [ID_W:0]        count_clamped;
    logic                 fifo_valid;
    logic [OCC_W-1:0]     fifo_occ;
    logic [ENT_W-1:0]     fifo_wr_data, fifo_rd_data;
    logic [TRI_WIDTH-1:0] head_data;
    logic [ID_W-1:0]      head_id;
    logic                 head_last;

    assign count_clamped = (tri_count_in > (ID_W+1)'(MAX_TRIS)) ? (ID_W+1)'(MAX_TRIS) : tri_count_in;
    assign pop_c         = fifo_valid & bus.ready_in;
    assign is_last_c     = (issue_cnt_q == last_id_q);

    // A read may issue only if its return is guaranteed a FIFO slot
    assign issue_c = (state_q == ST_ISSUE) &&
                     ((inflight_q + CR_W'(fifo_occ) - CR_W'(pop_c)) < CR_W'(FIFO_DEPTH));

    always_comb begin
        state_d      = state_q;
        issue_cnt_d  = issue_cnt_q;
        last_id_d    = last_id_q;
        frame_done_d = pop_c & head_last;
        case (state_q)
            ST_IDLE: begin
                if (frame_start_in) begin
                    if (count_clamped == '0) begin
                        frame_done_d = 1'b1;
                    end else begin
                        state_d     = ST_ISSUE;
                        issue_cnt_d = '0;
                        last_id_d   = ID_W'(count_clamped - (ID_W+1)'(1));
                    end
                end
            end
            ST_ISSUE: begin
                if (issue_c) begin
                    issue_cnt_d = issue_cnt_q + ID_W'(1);
                    if (is_last_c) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop_c && head_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Tag pipeline mirrors the BROM latency and is never stalled
    always_comb begin
        tag_vld_d     = '0;
        tag_last_d    = '0;
        tag_id_d      = '0;
        tag_vld_d[0]  = issue_c;
        tag_last_d[0] = issue_c && is_last_c;
        tag_id_d[0]   = issue_cnt_q;
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            tag_vld_d[i]  = tag_vld_q[i-1];
            tag_last_d[i] = tag_last_q[i-1];
            tag_id_d[i]   = tag_id_q[i-1];
        end
        inflight_d = inflight_q + CR_W'(issue_c) - CR_W'(tag_vld_q[READ_LATENCY-1]);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= ST_IDLE;
            issue_cnt_q  <= '0;
            last_id_q    <= '0;
            inflight_q   <= '0;
            tag_vld_q    <= '0;
            tag_last_q   <= '0;
            tag_id_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            issue_cnt_q  <= issue_cnt_d;
            last_id_q    <= last_id_d;
            inflight_q   <= inflight_d;
            tag_vld_q    <= tag_vld_d;
            tag_last_q   <= tag_last_d;
            tag_id_q     <= tag_id_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign fifo_wr_data = {bus.rom_data_in, tag_id_q[READ_LATENCY-1], tag_last_q[READ_LATENCY-1]};

    tri_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .wr_en     (tag_vld_q[READ_LATENCY-1]),
        .wr_data   (fifo_wr_data),
        .rd_en     (pop_c),
        .rd_data   (fifo_rd_data),
        .valid     (fifo_valid),
        .occupancy (fifo_occ)
    );

    assign {head_data, head_id, head_last} = fifo_rd_data;

    assign bus.rom_en_out       = issue_c;
    assign bus.rom_addr_out     = issue_cnt_q;
    assign bus.valid_out        = fifo_valid;
    assign bus.tri_vertices_out = tri_t'(head_data);
    assign bus.tri_id_out       = head_id;
    assign bus.last_tri_out     = head_last;
    assign busy_out             = (state_q != ST_IDLE);
    assign frame_done_out       = frame_done_q;

endmodule

// File: tb/tb_tri_fetch_sched.sv
// Directed-plus-random bench for tri_fetch_sched against a frame-level delivery model.
module tb_tri_fetch_sched;
    import graphics_pkg::*;

    localparam int unsigned MAX_TRIS = 1024;
    localparam int unsigned RL       = 2;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned ID_W     = 10;

    logic            clk_in = 1'b0;
    logic            rst_n_in;
    logic            frame_start_in;
    logic [ID_W:0]   tri_count_in;
    logic            busy_out;
    logic            frame_done_out;

    tri_fetch_sched_if #(.ID_W(ID_W)) bus ();

    tri_fetch_sched #(
        .MAX_TRIS     (MAX_TRIS),
        .READ_LATENCY (RL),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .frame_start_in (frame_start_in),
        .tri_count_in   (tri_count_in),
        .bus            (bus),
        .busy_out       (busy_out),
        .frame_done_out (frame_done_out)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;
    int first_issue_cyc, first_valid_cyc, last_hs_cyc, done_cyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_tri(input string tag, input tri_t obs, input tri_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] vert_val(input int id, input int v, input int c);
        return 16'(id * 9 + v * 3 + c) ^ 16'hA5C3;
    endfunction

    // BROM word laid out as data[48v+16c +: 16]
    function automatic logic [TRI_WIDTH-1:0] rom_word(input int id);
        logic [TRI_WIDTH-1:0] w;
        w = '0;
        for (int v = 0; v < 3; v++)
            for (int c = 0; c < 3; c++)
                w[48*v + 16*c +: 16] = vert_val(id, v, c);
        return w;
    endfunction

    function automatic tri_t exp_tri(input int id);
        tri_t t;
        for (int v = 0; v < 3; v++)
            for (int c = 0; c < 3; c++)
                t[v][c] = vert_val(id, v, c);
        return t;
    endfunction

    function automatic logic [TRI_WIDTH-1:0] junk_word();
        logic [159:0] j;
        j = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return j[TRI_WIDTH-1:0];
    endfunction

    // BROM model: data appears RL cycles after the strobe, garbage otherwise
    logic            rom_e1 = 1'b0;
    logic [ID_W-1:0] rom_a1 = '0;
    always @(posedge clk_in) begin
        bus.rom_data_in <= rom_e1 ? rom_word(int'(rom_a1)) : junk_word();
        rom_e1          <= bus.rom_en_out;
        rom_a1          <= bus.rom_addr_out;
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rom_en"},   64'(bus.rom_en_out),   64'(0));
        chk({tag, "_rom_addr"}, 64'(bus.rom_addr_out), 64'(0));
        chk({tag, "_valid"},    64'(bus.valid_out),    64'(0));
        chk_tri({tag, "_tri"},  bus.tri_vertices_out,  tri_t'(0));
        chk({tag, "_id"},       64'(bus.tri_id_out),   64'(0));
        chk({tag, "_last"},     64'(bus.last_tri_out), 64'(0));
        chk({tag, "_busy"},     64'(busy_out),         64'(0));
        chk({tag, "_done"},     64'(frame_done_out),   64'(0));
    endtask

    // mode 0: ready high, 1: ready low in cycles 5..20, 2: 50% random ready
    task automatic run_frame(input int n_req, input int mode, input bit junk_starts);
        int n, issued, popped, max_out, done_cnt, bad_stall, stray, c, budget, last_issue_cyc;
        bit stalled, rdy;
        logic [ID_W-1:0] h_id;
        logic h_last;
        tri_t h_tri;
        n = (n_req > int'(MAX_TRIS)) ? int'(MAX_TRIS) : n_req;
        issued = 0; popped = 0; max_out = 0; done_cnt = 0; bad_stall = 0; stray = 0;
        c = 0; budget = 3 * n + 60; last_issue_cyc = -1; stalled = 1'b0;
        h_id = '0; h_last = 1'b0; h_tri = '0;
        first_issue_cyc = -1; first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
        while (c < budget && !(done_cnt > 0 && c >= done_cyc + 3)) begin
            @(negedge clk_in);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = !(c >= 5 && c <= 20);
                default: rdy = ($urandom_range(0, 1) == 1);
            endcase
            bus.ready_in   = rdy;
            frame_start_in = (c == 0) ||
                             (junk_starts && (c == 3 || (last_issue_cyc >= 0 && c == last_issue_cyc + 1)));
            tri_count_in   = (c == 0) ? (ID_W+1)'(n_req) : (ID_W+1)'(5);
            #1;
            if (stalled && !(bus.valid_out && bus.tri_id_out == h_id &&
                             bus.last_tri_out == h_last && bus.tri_vertices_out == h_tri))
                bad_stall++;
            stalled = 1'b0;
            if (bus.rom_en_out) begin
                chk("issue_addr", 64'(bus.rom_addr_out), 64'(issued));
                if (first_issue_cyc < 0) first_issue_cyc = c;
                issued++;
                last_issue_cyc = c;
            end
            if (bus.valid_out && first_valid_cyc < 0) first_valid_cyc = c;
            if (bus.valid_out && rdy) begin
                chk("pop_id", 64'(bus.tri_id_out), 64'(popped));
                chk("pop_last", 64'(bus.last_tri_out), 64'(popped == n - 1));
                chk_tri("pop_tri", bus.tri_vertices_out, exp_tri(popped));
                popped++;
                last_hs_cyc = c;
            end else if (bus.valid_out) begin
                stalled = 1'b1;
                h_id    = bus.tri_id_out;
                h_last  = bus.last_tri_out;
                h_tri   = bus.tri_vertices_out;
            end
            if (issued - popped > max_out) max_out = issued - popped;
            if (frame_done_out) begin
                done_cnt++;
                if (done_cnt == 1) done_cyc = c;
            end
            if (done_cnt > 0 && (bus.valid_out || bus.rom_en_out || busy_out)) stray++;
            c++;
        end
        frame_start_in = 1'b0;
        chk("frame_finished", 64'(done_cnt > 0), 64'(1));
        chk("issued_count", 64'(issued), 64'(n));
        chk("delivered_count", 64'(popped), 64'(n));
        chk("done_pulses", 64'(done_cnt), 64'(1));
        chk("credit_limit", 64'(max_out <= int'(DEPTH)), 64'(1));
        chk("stall_hold", 64'(bad_stall), 64'(0));
        chk("after_done_quiet", 64'(stray), 64'(0));
        chk("done_timing", 64'(done_cyc), 64'((n == 0) ? 1 : last_hs_cyc + 1));
    endtask

    initial begin
        bit saw5;
        rst_n_in       = 1'b0;
        frame_start_in = 1'b0;
        tri_count_in   = '0;
        bus.ready_in   = 1'b0;
        repeat (3) @(negedge clk_in);
        #1;
        chk_all_zero("reset");
        @(negedge clk_in);
        rst_n_in = 1'b1;

        // full-rate frame, data=f(id)
        run_frame(12, 0, 1'b0);
        chk("fr_first_issue", 64'(first_issue_cyc), 64'(1));
        chk("fr_first_valid", 64'(first_valid_cyc), 64'(4));
        chk("fr_last_hs", 64'(last_hs_cyc), 64'(15));
        chk("fr_done", 64'(done_cyc), 64'(16));

        // backpressure window
        run_frame(12, 1, 1'b0);

        // zero count
        run_frame(0, 0, 1'b0);
        chk("zero_no_valid", 64'(first_valid_cyc), 64'(-1));
        chk("zero_done", 64'(done_cyc), 64'(1));

        // clamp to MAX_TRIS
        run_frame(2000, 0, 1'b0);
        chk("clamp_last_hs", 64'(last_hs_cyc), 64'(int'(MAX_TRIS) + 3));

        // starts during ISSUE and DRAIN are ignored
        run_frame(12, 0, 1'b1);
        chk("ign_last_hs", 64'(last_hs_cyc), 64'(15));

        // full-size frame with random ready, then a few random short frames
        run_frame(1024, 2, 1'b0);
        repeat (4) run_frame(int'($urandom_range(1, 40)), 2, 1'b0);

        // reset mid-frame at triangle 5 of 12
        saw5 = 1'b0;
        @(negedge clk_in);
        bus.ready_in   = 1'b1;
        frame_start_in = 1'b1;
        tri_count_in   = (ID_W+1)'(12);
        for (int k = 0; k < 40 && !saw5; k++) begin
            @(negedge clk_in);
            frame_start_in = 1'b0;
            #1;
            if (bus.valid_out && bus.tri_id_out == ID_W'(5)) saw5 = 1'b1;
        end
        chk("reached_tri5", 64'(saw5), 64'(1));
        @(negedge clk_in);
        rst_n_in = 1'b0;
        #1;
        chk_all_zero("midreset");
        repeat (2) @(negedge clk_in);
        #1;
        chk_all_zero("midreset_hold");
        @(negedge clk_in);
        rst_n_in = 1'b1;
        run_frame(3, 0, 1'b0);
        chk("post_reset_last_hs", 64'(last_hs_cyc), 64'(6));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
